// File: rtl/mcpu_core_fetch_pkg.sv
// Shared defaults and the fetch-queue entry layout for the MCPU fetch stage.
package mcpu_core_fetch_pkg;

  localparam int FQ_ADDR_W  = 28;
  localparam int FQ_DATA_W  = 128;
  localparam int FQ_QDEPTH  = 4;
  localparam int FQ_PC_STEP = 1;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic                 pf;
    logic [FQ_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/mcpu_core_fetch_fifo.sv
// Generic power-of-two FIFO with synchronous clear; head is read straight from storage.
module mcpu_core_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // Upstream credit accounting must never let a push land on a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !clr && !do_pop && count_q == (AW+1)'(DEPTH)));

endmodule

// File: rtl/mcpu_core_fetch_queue.sv
// Instruction fetch stage: issues sequential I$ requests under queue credit and buffers
// returned packets for decode; a page-faulting packet halts issue until the next flush.
module mcpu_core_fetch_queue
  import mcpu_core_fetch_pkg::*;
#(
  parameter int ADDR_W  = FQ_ADDR_W,
  parameter int DATA_W  = FQ_DATA_W,
  parameter int QDEPTH  = FQ_QDEPTH,
  parameter int PC_STEP = FQ_PC_STEP
) (
  input  logic              clkrst_core_clk,
  input  logic              clkrst_core_rst,
  input  logic              pipe_flush,
  input  logic [ADDR_W-1:0] pc2f_newpc,
  input  logic              f_valid_in,
  output logic              f_ready_out,
  output logic              f_valid_out,
  input  logic              f_out_ok,
  output logic [ADDR_W-1:0] f2d_out_virtpc,
  output logic [DATA_W-1:0] f2d_out_data,
  output logic              f2d_out_inst_pf,
  output logic [ADDR_W-1:0] f2ic_vaddr,
  output logic              f2ic_valid,
  input  logic              ic2f_ready,
  input  logic              ic2f_rsp_valid,
  input  logic [DATA_W-1:0] ic2f_rsp_data,
  input  logic              ic2f_rsp_pf
);

  localparam int EW = ADDR_W + 1 + DATA_W;
  localparam int CW = $clog2(QDEPTH);

  logic [ADDR_W-1:0] virtpc_q, virtpc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d;
  logic              drop_q, drop_d;

  logic [CW:0]       q_count;
  logic [CW+1:0]     occupancy;
  logic              credit, accept, push, pop;
  logic [EW-1:0]     push_entry, head_entry;
  logic              head_pf;

  always_comb begin
    occupancy   = {1'b0, q_count} + {{(CW+1){1'b0}}, inflight_q};
    credit      = occupancy < (CW+2)'(QDEPTH);
    // Reset is folded in so no request escapes while the core is held in reset.
    f_ready_out = credit && !halted_q && !pipe_flush && !clkrst_core_rst;
    f2ic_valid  = f_ready_out && f_valid_in;
    accept      = f2ic_valid && ic2f_ready;
    push        = ic2f_rsp_valid && inflight_q && !drop_q && !pipe_flush;
    pop         = f_valid_out && f_out_ok;
    push_entry  = {rsp_pc_q, ic2f_rsp_pf, ic2f_rsp_data};

    virtpc_d   = virtpc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q && !ic2f_rsp_valid;
    halted_d   = halted_q || (push && ic2f_rsp_pf);
    drop_d     = 1'b0;
    if (pipe_flush) begin
      virtpc_d   = pc2f_newpc;
      inflight_d = 1'b0;
      halted_d   = 1'b0;
      drop_d     = inflight_q;
    end else if (accept) begin
      virtpc_d   = virtpc_q + ADDR_W'(PC_STEP);
      rsp_pc_d   = virtpc_q;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
    if (clkrst_core_rst) begin
      virtpc_q   <= '0;
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      virtpc_q   <= virtpc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
      drop_q     <= drop_d;
    end
  end

  mcpu_core_fetch_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clkrst_core_clk),
    .rst   (clkrst_core_rst),
    .clr   (pipe_flush),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .count (q_count)
  );

  assign f_valid_out = (q_count != '0);
  assign {f2d_out_virtpc, head_pf, f2d_out_data} = head_entry;
  assign f2d_out_inst_pf = f_valid_out && head_pf;
  assign f2ic_vaddr = virtpc_q;

endmodule
